genesis_pad_scanner: RTL and testbench

- Sequencer for the SEGA Genesis DB-9 pad port: drives the Select pin and samples the six data pins in each Select phase at a fixed cadence.
- Assembles one 11-bit button word per scan, with held and rising-edge (pressed) views, plus pad-presence detection.
- Sits between the board DB-9 pins and game/robot control logic; replaces the externally driven select and per-sample edge logic.
- The scan period is the debounce mechanism; no separate debouncers are needed.

---
 rtl/genesis_pad_scanner.sv | 147 ++++++++++++++
 tb/tb_genesis_pad_scanner.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genesis_pad_scanner.sv
// rtl/genesis_pad_scanner.sv - Genesis DB-9 pad select sequencer and button scanner (option: SIX_BUTTON_EN)
module genesis_pad_scanner #(
    parameter int SETTLE_CYCLES = 50,
    parameter int SCAN_PERIOD   = 833333
) (
    input  logic        clock_50,
    input  logic        reset_key,
    input  logic        scan_en,
    input  logic        up_z,
    input  logic        down_y,
    input  logic        left_x,
    input  logic        right,
    input  logic        a_b,
    input  logic        start_c,
    output logic        select_out,
    output logic [10:0] buttons_held,
    output logic [10:0] buttons_pressed,
    output logic        pad_present,
    output logic        scan_done
);

    typedef enum logic [2:0] {
        IDLE,
        LO1,
        HI1,
`ifdef SIX_BUTTON_EN
        LO2,
        HI2,
        LO3,
        HI3,
`endif
        PUBLISH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        select_next;
    logic [19:0] period_cnt;
    logic [7:0]  settle_cnt;
    logic        period_end;
    logic        settle_end;
    logic [5:0]  pins_meta;
    logic [5:0]  pins_sync;
    logic [10:0] samp;
    logic [10:0] new_word;
    logic        detect;
`ifdef SIX_BUTTON_EN
    logic        six_detect;
`endif

    logic s_up, s_down, s_left, s_right, s_ab, s_startc;
    assign {s_startc, s_ab, s_right, s_left, s_down, s_up} = pins_sync;

    assign period_end = (period_cnt <= 20'd1);
    assign settle_end = (settle_cnt == 8'(SETTLE_CYCLES - 1));
    assign new_word   = detect ? samp : 11'd0;

    // Pad pins are asynchronous to clock_50; idle (released) level is high.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            pins_meta <= 6'h3f;
            pins_sync <= 6'h3f;
        end else begin
            pins_meta <= {start_c, a_b, right, left_x, down_y, up_z};
            pins_sync <= pins_meta;
        end
    end

    always_comb begin
        state_next  = state;
        select_next = 1'b1;
        case (state)
            IDLE:    if (period_end && scan_en) state_next = LO1;
            LO1:     if (settle_end) state_next = HI1;
`ifdef SIX_BUTTON_EN
            HI1:     if (settle_end) state_next = LO2;
            LO2:     if (settle_end) state_next = HI2;
            HI2:     if (settle_end) state_next = LO3;
            LO3:     if (settle_end) state_next = HI3;
            HI3:     if (settle_end) state_next = PUBLISH;
`else
            HI1:     if (settle_end) state_next = PUBLISH;
`endif
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Select is registered from the state being entered, so it flips on the entry edge.
        case (state_next)
            LO1:     select_next = 1'b0;
`ifdef SIX_BUTTON_EN
            LO2:     select_next = 1'b0;
            LO3:     select_next = 1'b0;
`endif
            default: select_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            state           <= IDLE;
            select_out      <= 1'b1;
            period_cnt      <= 20'(SCAN_PERIOD);
            settle_cnt      <= 8'd0;
            samp            <= 11'd0;
            detect          <= 1'b0;
`ifdef SIX_BUTTON_EN
            six_detect      <= 1'b0;
`endif
            buttons_held    <= 11'd0;
            buttons_pressed <= 11'd0;
            pad_present     <= 1'b0;
            scan_done       <= 1'b0;
        end else begin
            state           <= state_next;
            select_out      <= select_next;
            scan_done       <= 1'b0;
            buttons_pressed <= 11'd0;
            settle_cnt      <= (state == IDLE || state_next != state) ? 8'd0 : settle_cnt + 8'd1;
            case (state)
                IDLE: period_cnt <= period_end ? 20'(SCAN_PERIOD) : period_cnt - 20'd1;
                LO1: if (settle_end) begin
                    samp[4] <= ~s_ab;
                    samp[5] <= ~s_startc;
                    detect  <= ~s_left & ~s_right;
                end
                HI1: if (settle_end) begin
                    samp[3:0] <= ~{s_right, s_left, s_down, s_up};
                    samp[9]   <= ~s_ab;
                    samp[10]  <= ~s_startc;
                end
`ifdef SIX_BUTTON_EN
                LO3: if (settle_end) six_detect <= ~s_up & ~s_down;
                HI3: if (settle_end) samp[8:6] <= six_detect ? ~{s_left, s_down, s_up} : 3'b000;
`endif
                PUBLISH: begin
                    buttons_pressed <= new_word & ~buttons_held;
                    buttons_held    <= new_word;
                    pad_present     <= detect;
                    scan_done       <= 1'b1;
                    period_cnt      <= 20'(SCAN_PERIOD);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// tb/tb_genesis_pad_scanner.sv - self-checking bench for genesis_pad_scanner with a behavioural pad model
module tb_genesis_pad_scanner;

    localparam int SETTLE = 4;
    localparam int PERIOD = 64;
`ifdef SIX_BUTTON_EN
    localparam int SCAN_LEN = 6 * SETTLE + 1;
`else
    localparam int SCAN_LEN = 2 * SETTLE + 1;
`endif
    localparam int TOTAL = PERIOD + SCAN_LEN;

    logic        clock_50 = 1'b0;
    logic        reset_key;
    logic        scan_en;
    logic        up_z, down_y, left_x, right, a_b, start_c;
    logic        select_out;
    logic [10:0] buttons_held;
    logic [10:0] buttons_pressed;
    logic        pad_present;
    logic        scan_done;

    int errors = 0;
    int checks = 0;

    bit          connected = 1'b1;
    bit          six_pad   = 1'b0;
    logic [10:0] btn       = 11'd0;
    int          lowcnt    = 0;
    logic        prev_sel  = 1'b1;
    logic [10:0] exp_held;

    genesis_pad_scanner #(.SETTLE_CYCLES(SETTLE), .SCAN_PERIOD(PERIOD)) dut (
        .clock_50(clock_50), .reset_key(reset_key), .scan_en(scan_en),
        .up_z(up_z), .down_y(down_y), .left_x(left_x), .right(right),
        .a_b(a_b), .start_c(start_c), .select_out(select_out),
        .buttons_held(buttons_held), .buttons_pressed(buttons_pressed),
        .pad_present(pad_present), .scan_done(scan_done)
    );

    always #5 clock_50 = ~clock_50;

    // Six-button pads count select falling edges; the third low/high pair is special.
    always @(negedge clock_50) begin
        if (!reset_key || scan_done) lowcnt = 0;
        else if (prev_sel && !select_out) lowcnt = lowcnt + 1;
        prev_sel = select_out;
    end

    always @* begin
        if (!connected) begin
            {up_z, down_y, left_x, right, a_b, start_c} = 6'h3f;
        end else if (select_out) begin
            if (six_pad && lowcnt == 3)
                {up_z, down_y, left_x, right} = {~btn[6], ~btn[7], ~btn[8], 1'b1};
            else
                {up_z, down_y, left_x, right} = ~{btn[0], btn[1], btn[2], btn[3]};
            a_b     = ~btn[9];
            start_c = ~btn[10];
        end else begin
            if (six_pad && lowcnt == 3)
                {up_z, down_y} = 2'b00;
            else
                {up_z, down_y} = ~{btn[0], btn[1]};
            left_x  = 1'b0;
            right   = 1'b0;
            a_b     = ~btn[4];
            start_c = ~btn[5];
        end
    end

    function automatic logic [10:0] model_word();
        logic [10:0] w;
        w = btn & 11'h63f;
`ifdef SIX_BUTTON_EN
        if (six_pad) w[8:6] = btn[8:6];
        else if (btn[0] && btn[1]) w[8:6] = {btn[2], btn[1], btn[0]};
`endif
        if (!connected) w = 11'd0;
        return w;
    endfunction

    task automatic wait_done(input int budget, output int cycles);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clock_50);
            n++;
            if (scan_done) begin
                cycles = n;
                return;
            end
        end
        cycles = -1;
    endtask

    task automatic test_reset();
        checks++;
        if (select_out !== 1'b1) begin errors++; $display("FAIL reset_select got=%b exp=1", select_out); end
        checks++;
        if ({buttons_held, buttons_pressed, pad_present, scan_done} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs held=%h pressed=%h present=%b done=%b exp all 0",
                     buttons_held, buttons_pressed, pad_present, scan_done);
        end
    endtask

    task automatic test_three_button();
        int c;
        btn = 11'h410;
        reset_key = 1'b1;
        wait_done(TOTAL + 20, c);
        checks++;
        if (c != TOTAL) begin errors++; $display("FAIL first_scan_latency got=%0d exp=%0d", c, TOTAL); end
        checks++;
        if (buttons_held !== 11'h410 || buttons_pressed !== 11'h410 || pad_present !== 1'b1) begin
            errors++;
            $display("FAIL ac_scan1 held=%h pressed=%h present=%b exp 410/410/1",
                     buttons_held, buttons_pressed, pad_present);
        end
        @(negedge clock_50);
        checks++;
        if (buttons_pressed !== 11'd0 || scan_done !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width pressed=%h done=%b exp 0/0", buttons_pressed, scan_done);
        end
        wait_done(TOTAL + 20, c);
        checks++;
        if (c != TOTAL - 1 || buttons_held !== 11'h410 || buttons_pressed !== 11'd0) begin
            errors++;
            $display("FAIL ac_scan2 cycles=%0d held=%h pressed=%h exp %0d/410/0",
                     c, buttons_held, buttons_pressed, TOTAL - 1);
        end
    endtask

    task automatic test_reset_mid_scan();
        int c;
        int bad;
        repeat (PERIOD + 5) @(negedge clock_50);
        checks++;
        if (select_out !== 1'b1) begin errors++; $display("FAIL in_hi1_select got=%b exp=1", select_out); end
        reset_key = 1'b0;
        #1;
        checks++;
        if (select_out !== 1'b1 || {buttons_held, buttons_pressed, pad_present, scan_done} !== 24'd0) begin
            errors++;
            $display("FAIL async_reset select=%b held=%h pressed=%h present=%b done=%b exp 1/0/0/0/0",
                     select_out, buttons_held, buttons_pressed, pad_present, scan_done);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_50);
            if (scan_done !== 1'b0 || select_out !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_hold bad_cycles=%0d exp=0", bad); end
        reset_key = 1'b1;
        wait_done(TOTAL + 20, c);
        checks++;
        if (c != TOTAL) begin errors++; $display("FAIL post_reset_latency got=%0d exp=%0d", c, TOTAL); end
    endtask

    task automatic test_unplugged();
        int c;
        connected = 1'b0;
        wait_done(TOTAL + 20, c);
        checks++;
        if (c != TOTAL || buttons_held !== 11'd0 || pad_present !== 1'b0) begin
            errors++;
            $display("FAIL unplugged_scan1 cycles=%0d held=%h present=%b exp %0d/0/0",
                     c, buttons_held, pad_present, TOTAL);
        end
        wait_done(TOTAL + 20, c);
        checks++;
        if (c != TOTAL || buttons_held !== 11'd0 || buttons_pressed !== 11'd0 || pad_present !== 1'b0) begin
            errors++;
            $display("FAIL unplugged_scan2 cycles=%0d held=%h pressed=%h present=%b exp %0d/0/0/0",
                     c, buttons_held, buttons_pressed, pad_present, TOTAL);
        end
    endtask

    task automatic test_release();
        int c;
        connected = 1'b1;
        btn = 11'd0;
        wait_done(TOTAL + 20, c);
        btn = 11'h001;
        wait_done(TOTAL + 20, c);
        checks++;
        if (buttons_held !== 11'h001 || buttons_pressed !== 11'h001 || pad_present !== 1'b1) begin
            errors++;
            $display("FAIL up_press held=%h pressed=%h present=%b exp 001/001/1",
                     buttons_held, buttons_pressed, pad_present);
        end
        btn = 11'd0;
        wait_done(TOTAL + 20, c);
        checks++;
        if (buttons_held !== 11'd0 || buttons_pressed !== 11'd0) begin
            errors++;
            $display("FAIL up_release held=%h pressed=%h exp 0/0", buttons_held, buttons_pressed);
        end
        repeat (20) @(negedge clock_50);
        btn = 11'h001;
        repeat (2) @(negedge clock_50);
        btn = 11'd0;
        wait_done(TOTAL + 20, c);
        checks++;
        if (buttons_held !== 11'd0 || buttons_pressed !== 11'd0) begin
            errors++;
            $display("FAIL glitch_ignored held=%h pressed=%h exp 0/0", buttons_held, buttons_pressed);
        end
    endtask

    task automatic test_scan_en();
        int c;
        int bad;
        repeat (PERIOD + 2) @(negedge clock_50);
        checks++;
        if (select_out !== 1'b0) begin errors++; $display("FAIL lo1_select got=%b exp=0", select_out); end
        scan_en = 1'b0;
        wait_done(TOTAL, c);
        checks++;
        if (c != TOTAL - PERIOD - 2) begin
            errors++;
            $display("FAIL scan_en_completes got=%0d exp=%0d", c, TOTAL - PERIOD - 2);
        end
        bad = 0;
        for (int i = 0; i < 3 * TOTAL; i++) begin
            @(negedge clock_50);
            if (scan_done !== 1'b0 || select_out !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL scan_disabled_idle bad_cycles=%0d exp=0", bad); end
        scan_en = 1'b1;
        wait_done(2 * TOTAL, c);
        checks++;
        if (c < SCAN_LEN || c > TOTAL) begin
            errors++;
            $display("FAIL scan_resume got=%0d exp %0d..%0d", c, SCAN_LEN, TOTAL);
        end
    endtask

    task automatic test_random();
        int c;
        logic [10:0] w;
        connected = 1'b1;
        six_pad = 1'b0;
        btn = 11'd0;
        wait_done(TOTAL + 20, c);
        exp_held = 11'd0;
        for (int i = 0; i < 12; i++) begin
            btn = 11'($urandom);
            connected = ($urandom_range(0, 5) != 0);
`ifdef SIX_BUTTON_EN
            six_pad = $urandom_range(0, 1) != 0;
`endif
            w = model_word();
            wait_done(TOTAL + 20, c);
            checks++;
            if (c != TOTAL || buttons_held !== w || buttons_pressed !== (w & ~exp_held)
                || pad_present !== connected) begin
                errors++;
                $display("FAIL random_scan%0d cycles=%0d held=%h pressed=%h present=%b exp %0d/%h/%h/%b",
                         i, c, buttons_held, buttons_pressed, pad_present,
                         TOTAL, w, w & ~exp_held, connected);
            end
            exp_held = w;
        end
        connected = 1'b1;
        six_pad = 1'b0;
    endtask

`ifdef SIX_BUTTON_EN
    task automatic test_six();
        int c;
        int bad;
        six_pad = 1'b1;
        btn = 11'h300;
        bad = 0;
        for (int j = 1; j <= PERIOD + 24; j++) begin
            @(negedge clock_50);
            if (j >= PERIOD + 2 && ((j - PERIOD - 2) % 4) == 0)
                if (select_out !== (((j - PERIOD - 2) / 4) % 2 == 1)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL six_select_pattern bad=%0d exp=0", bad); end
        wait_done(20, c);
        checks++;
        if (c != 1 || buttons_held !== 11'h300) begin
            errors++;
            $display("FAIL six_xb cycles=%0d held=%h exp 1/300", c, buttons_held);
        end
        six_pad = 1'b0;
        wait_done(TOTAL + 20, c);
        checks++;
        if (buttons_held !== 11'h200) begin
            errors++;
            $display("FAIL six_mode_3pad held=%h exp 200", buttons_held);
        end
    endtask
`endif

    initial begin
        reset_key = 1'b0;
        scan_en   = 1'b1;
        repeat (3) @(negedge clock_50);
        test_reset();
        test_three_button();
        test_reset_mid_scan();
        test_unplugged();
        test_release();
        test_scan_en();
        test_random();
`ifdef SIX_BUTTON_EN
        test_six();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
